// File: rtl/lcm_pkg.sv
// Shared definitions for the LCM stage: FSM state encoding, default operand
// width, counter width and the length of the result hold window.
package lcm_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int CNT_W       = 5;
  localparam int FINISH_HOLD = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GCD = 3'd1,
    DIV      = 3'd2,
    MUL      = 3'd3,
    FINISH   = 3'd4
  } state_e;

endpackage

// File: rtl/lcm_calculator_if.sv
// Handshake/data bundle between the GCD front end and the LCM stage.
// Optional macro LCM_CHECK_EN adds the err flag to the bundle.
interface lcm_calculator_if
  import lcm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 gcd_done;
  logic [WIDTH-1:0]     gcd_in;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   lcm;
`ifdef LCM_CHECK_EN
  logic                 err;

  modport master (
    output start, a, b, gcd_done, gcd_in,
    input  busy, done, lcm, err
  );

  modport slave (
    input  start, a, b, gcd_done, gcd_in,
    output busy, done, lcm, err
  );
`else
  modport master (
    output start, a, b, gcd_done, gcd_in,
    input  busy, done, lcm
  );

  modport slave (
    input  start, a, b, gcd_done, gcd_in,
    output busy, done, lcm
  );
`endif

endinterface

// File: rtl/lcm_calculator_seq_divider.sv
// seq_divider: WIDTH-cycle unsigned restoring divider. A go pulse loads the
// operands; one quotient bit is produced per cycle, MSB first. ready rises
// once quotient/remainder are final and stays high until the next go.
module seq_divider
  import lcm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // quo_q starts as the dividend and is shifted left each step; the vacated
  // LSB collects the quotient bit, so after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             ready_q, ready_d;
  logic [WIDTH:0]   shifted;

  // Load on go, otherwise perform one restoring step per cycle while running
  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    ready_d = ready_q;
    shifted = {rem_q, quo_q[WIDTH-1]};
    if (go) begin
      quo_d   = dividend;
      rem_d   = '0;
      dvs_d   = divisor;
      cnt_d   = CNT_LAST;
      run_d   = 1'b1;
      ready_d = 1'b0;
    end else if (run_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = WIDTH'(shifted - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
      if (cnt_q == '0) begin
        run_d   = 1'b0;
        ready_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      ready_q <= ready_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign ready     = ready_q;

endmodule

// File: rtl/lcm_calculator.sv
// lcm_calculator: sits behind the GCD engine and forms lcm = (a / gcd) * b
// with a sequential divider followed by an inline shift-add multiplier.
// Optional macro LCM_CHECK_EN adds err, flagging a gcd that does not divide
// both operands (the result still uses the truncated quotient).
module lcm_calculator
  import lcm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  lcm_calculator_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FINISH_HOLD - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] lcm_q, lcm_d;
  logic               done_q, done_d;

  logic               div_go;
  logic               div_ready;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_rem;
  logic [WIDTH-1:0]   quo_shift;
  logic               mul_bit;

`ifdef LCM_CHECK_EN
  logic               err_q, err_d;
  logic [WIDTH-1:0]   chk_rem_q, chk_rem_d;
  logic [WIDTH-1:0]   b_shift;
  logic [WIDTH:0]     chk_shifted;
`endif

  // gcd_in is only valid while gcd_done is high, so the divider takes it
  // straight from the bus on the same edge that launches it.
  seq_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .go        (div_go),
    .dividend  (a_q),
    .divisor   (bus.gcd_in),
    .quotient  (div_quo),
    .remainder (div_rem),
    .ready     (div_ready)
  );

  // Next-state and datapath updates for the launch/divide/multiply/hold sequence
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    gcd_d     = gcd_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    lcm_d     = lcm_q;
    done_d    = done_q;
    div_go    = 1'b0;
    quo_shift = div_quo >> cnt_q;
    mul_bit   = quo_shift[0];
`ifdef LCM_CHECK_EN
    err_d       = err_q;
    chk_rem_d   = chk_rem_q;
    b_shift     = b_q >> cnt_q;
    chk_shifted = {chk_rem_q, b_shift[0]};
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = WAIT_GCD;
        end
      end
      WAIT_GCD: begin
        if (bus.gcd_done) begin
          gcd_d = bus.gcd_in;
          if ((a_q == '0) || (b_q == '0)) begin
            lcm_d   = '0;
            done_d  = 1'b1;
            cnt_d   = HOLD_LAST;
            state_d = FINISH;
`ifdef LCM_CHECK_EN
            err_d   = 1'b0;
`endif
          end else begin
            div_go  = 1'b1;
            prod_d  = '0;
            cnt_d   = CNT_LAST;
            state_d = DIV;
`ifdef LCM_CHECK_EN
            chk_rem_d = '0;
`endif
          end
        end
      end
      DIV: begin
`ifdef LCM_CHECK_EN
        // Remainder-only pass of b / gcd, one bit per divider cycle
        if (chk_shifted >= {1'b0, gcd_q}) begin
          chk_rem_d = WIDTH'(chk_shifted - {1'b0, gcd_q});
        end else begin
          chk_rem_d = chk_shifted[WIDTH-1:0];
        end
`endif
        if (cnt_q == '0) begin
          cnt_d   = CNT_LAST;
          state_d = MUL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MUL: begin
        // MSB-first shift-add: product = 2*product + (q bit ? b : 0)
        if (div_ready) begin
          prod_d = {prod_q[2*WIDTH-2:0], 1'b0} +
                   (mul_bit ? {{WIDTH{1'b0}}, b_q} : {2*WIDTH{1'b0}});
          if (cnt_q == '0) begin
            lcm_d   = prod_d;
            done_d  = 1'b1;
            cnt_d   = HOLD_LAST;
            state_d = FINISH;
`ifdef LCM_CHECK_EN
            err_d   = (chk_rem_q != '0) || (div_rem != '0);
`endif
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      FINISH: begin
        if (cnt_q == '0) begin
          done_d  = 1'b0;
          lcm_d   = '0;
          state_d = IDLE;
`ifdef LCM_CHECK_EN
          err_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so an aborted run leaves no trace
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      lcm_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      lcm_q   <= lcm_d;
      done_q  <= done_d;
    end
  end

`ifdef LCM_CHECK_EN
  // Divisibility-check registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      chk_rem_q <= '0;
    end else begin
      err_q     <= err_d;
      chk_rem_q <= chk_rem_d;
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.lcm  = lcm_q;

  // Once multiplying, the divider has finished and its remainder must be below the gcd
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state_q == MUL) |-> (div_rem < gcd_q));

endmodule
